pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline stage register carrying an instruction word and its PC between two pipeline stages. It replaces the fixed single-entry stall/flush register with a valid/ready handshake on both sides, a DEPTH-entry circular buffer, and a synchronous flush that discards all held entries. It sits at any stage boundary, first at IF→ID, where an instruction cache with variable latency must decouple from the decoder.

## Interface
Parameters:
- INSTR_W, default 32: instruction payload width.
- PC_W, default 32: PC payload width.
- DEPTH, default 2: buffer entries. Legal values are 1, 2, 4 and 8. DEPTH ≥ 2 is needed for full throughput.
- NOP_INSTR, default 32'h0000_0000: value on instr_o while the buffer is empty.

Ports:
- clk_i, input, 1: clock. All state updates on its rising edge.
- rst_n_i, input, 1: reset, asynchronous, active-low.
- flush_i, input, 1: synchronous flush. Discards every entry.
- in_valid_i, input, 1: upstream offers a payload.
- in_ready_o, output, 1: buffer can accept a payload.
- instr_i, input, INSTR_W: incoming instruction.
- pc_i, input, PC_W: incoming PC.
- out_valid_o, output, 1: head entry is valid.
- out_ready_i, input, 1: downstream accepts the head entry.
- instr_o, output, INSTR_W: head instruction, or NOP_INSTR when empty.
- pc_o, output, PC_W: head PC, or 0 when empty.
- stall_cnt_o, output, 16: present only with the configuration macro.
- flush_cnt_o, output, 16: present only with the configuration macro.

## Operation
- **State:** storage array[DEPTH], write pointer wp, read pointer rp, occupancy count (0..DEPTH).
  - Pointers wrap modulo DEPTH, from DEPTH-1 to 0.
- **Push:** a push occurs when in_valid_i & in_ready_o. It writes the payload to array[wp] and increments wp.
- **Pop:** a pop occurs when out_valid_o & out_ready_i. It increments rp.
- **Flags:**
  - in_ready_o = (count != DEPTH).
  - out_valid_o = (count != 0).
  - Both are decoded from registered count only. There is no combinational path from out_ready_i or flush_i to any output.
- **Count update:** count += push − pop. Push and pop may occur in the same cycle, including when count == DEPTH−1 or count == 1.
- **Full:** when count == DEPTH, in_ready_o = 0 even if a pop occurs the same cycle, so no same-cycle refill. With DEPTH = 1, throughput is therefore at most one transfer every 2 cycles.
- **Empty:** when count == 0:
  - instr_o = NOP_INSTR and pc_o = 0.
  - There is no bypass: a push appears at the output one cycle later.
- **Flush:** flush_i has priority over push and pop.
  - At the edge: count = 0, wp = rp = 0.
  - A push offered in the flush cycle is accepted (the handshake completes) but discarded.
  - A pop handshake in the flush cycle is valid: downstream keeps the head entry it sampled.
- **Reset:** rst_n_i low asynchronously sets count = 0 and wp = rp = 0. Storage contents are not reset.
  - Outputs during reset and after release: out_valid_o = 0, in_ready_o = 1, instr_o = NOP_INSTR, pc_o = 0, counters 0.
  - Reset asserted mid-stream drops all entries immediately, without waiting for a clock edge.

## Timing
- **Latency:** payload pushed at edge N is on instr_o/pc_o with out_valid_o = 1 after edge N, when the buffer was empty before N.
- **Order:** entries leave in strict FIFO order.
- **Output stability:** while out_valid_o = 1 and out_ready_i = 0, instr_o and pc_o hold stable.
- **Throughput:** DEPTH ≥ 2 sustains 1 transfer/cycle with out_ready_i held high.
- **Flush timing:** flush_i asserted in cycle N makes out_valid_o = 0 from edge N onward. in_ready_o = 1 in cycle N+1.

## Configuration
- **PIPE_STAGE_BUF_PERF_EN defined:**
  - stall_cnt_o increments each cycle that out_valid_o = 1 and out_ready_i = 0.
  - flush_cnt_o increments each cycle flush_i = 1 while count != 0.
  - Both counters are 16 bits and saturate at 16'hFFFF.
  - Both are cleared only by reset.
- **PIPE_STAGE_BUF_PERF_EN undefined:** both ports and both counters are absent. Behaviour is otherwise identical.

## Test plan
- **Reset:** rst_n_i low mid-cycle with 2 entries held → out_valid_o = 0, in_ready_o = 1, instr_o = NOP_INSTR, pc_o = 0 before the next clock edge.
- **Streaming:** DEPTH = 2, out_ready_i = 1, push instr 0xA0..0xA7 with pc 0x100..0x11C on consecutive cycles → same sequence out, one cycle later each, no gaps.
- **Fill and drain:** DEPTH = 4, out_ready_i = 0, push 5 payloads.
  - The 4th push leaves count = 4 and in_ready_o = 0, so the 5th push is held off.
  - out_ready_i = 1 then drains in order, and in_ready_o returns to 1 after the first pop.
- **Wrap-around:** DEPTH = 2, run 10 push/pop cycles with random out_ready_i → scoreboard order matches and pointers wrap without loss.
- **Flush with simultaneous events:** count = 3, push and pop in the same cycle as flush_i → the popped head is delivered, the pushed entry is dropped, and out_valid_o = 0 next cycle. With the macro, flush_cnt_o = 1.
- **Counter saturation (macro defined):** hold out_valid_o = 1 and out_ready_i = 0 for 70000 cycles → stall_cnt_o = 16'hFFFF and stays there.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline stage register carrying {instr, pc}
// between two stages, with a DEPTH-entry circular buffer, valid/ready on
// both sides and a synchronous flush that drops all held entries.
// Optional build macro PIPE_STAGE_BUF_PERF_EN adds saturating 16-bit
// stall/flush counters and their output ports.
module pipe_stage_buf #(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [15:0]        stall_cnt_o,
  output logic [15:0]        flush_cnt_o
`endif
);

  localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [PC_W-1:0]    pc_mem_d    [DEPTH];
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [PTR_W-1:0]   rp_q, rp_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push;
  logic               pop;

  // Handshake flags decode registered occupancy only; full blocks refill
  // even when a pop happens in the same cycle.
  always_comb begin
    in_ready_o  = (count_q != CNT_FULL);
    out_valid_o = (count_q != '0);
    push        = in_valid_i & in_ready_o;
    pop         = out_valid_o & out_ready_i;
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush_i) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
      if (pop)  rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write on push; a push during flush lands in a slot that the
  // reset pointers make unreachable, so it is effectively discarded.
  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (push) begin
      instr_mem_d[wp_q] = instr_i;
      pc_mem_d[wp_q]    = pc_i;
    end
  end

  // Control state: asynchronous active-low reset empties the buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  // Head entry, or NOP/zero when empty (no bypass from the input).
  always_comb begin
    instr_o = out_valid_o ? instr_mem_q[rp_q] : NOP_INSTR;
    pc_o    = out_valid_o ? pc_mem_q[rp_q]    : '0;
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: downstream back-pressure and non-empty flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_i && (count_q != '0) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counters are cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Counter outputs.
  always_comb begin
    stall_cnt_o = stall_cnt_q;
    flush_cnt_o = flush_cnt_q;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=4 instance share one
// stimulus stream; each is checked against a queue-based reference model.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              out_ready;
  logic [31:0]       instr_in;
  logic [31:0]       pc_in;
  logic [1:0]        in_ready;
  logic [1:0]        out_valid;
  logic [1:0][31:0]  instr_out;
  logic [1:0][31:0]  pc_out;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [1:0][15:0]  stall_cnt;
  logic [1:0][15:0]  flush_cnt;
`endif

  pipe_stage_buf #(.INSTR_W(32), .PC_W(32), .DEPTH(2)) u_d2 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready[0]),
    .instr_i     (instr_in),
    .pc_i        (pc_in),
    .out_valid_o (out_valid[0]),
    .out_ready_i (out_ready),
    .instr_o     (instr_out[0]),
    .pc_o        (pc_out[0])
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    .stall_cnt_o (stall_cnt[0]),
    .flush_cnt_o (flush_cnt[0])
`endif
  );

  pipe_stage_buf #(.INSTR_W(32), .PC_W(32), .DEPTH(4), .NOP_INSTR(32'h0000_0013)) u_d4 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready[1]),
    .instr_i     (instr_in),
    .pc_i        (pc_in),
    .out_valid_o (out_valid[1]),
    .out_ready_i (out_ready),
    .instr_o     (instr_out[1]),
    .pc_o        (pc_out[1])
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    .stall_cnt_o (stall_cnt[1]),
    .flush_cnt_o (flush_cnt[1])
`endif
  );

  // Reference model: one FIFO queue of {instr, pc} per instance.
  int unsigned depth [2];
  logic [31:0] nop   [2];
  logic [63:0] mq    [2][$];
  int unsigned m_stall [2];
  int unsigned m_flush [2];

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_stall[i] = 0;
      m_flush[i] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int unsigned n    = mq[i].size();
      logic [63:0] head = (n != 0) ? mq[i][0] : 64'd0;
      logic [31:0] e_in = (n != 0) ? head[63:32] : nop[i];
      logic [31:0] e_pc = (n != 0) ? head[31:0] : 32'd0;
      chk($sformatf("in_ready[d%0d]", depth[i]),  64'(in_ready[i]),  64'(n != depth[i]));
      chk($sformatf("out_valid[d%0d]", depth[i]), 64'(out_valid[i]), 64'(n != 0));
      chk($sformatf("instr_o[d%0d]", depth[i]),   64'(instr_out[i]), 64'(e_in));
      chk($sformatf("pc_o[d%0d]", depth[i]),      64'(pc_out[i]),    64'(e_pc));
`ifdef PIPE_STAGE_BUF_PERF_EN
      chk($sformatf("stall_cnt[d%0d]", depth[i]), 64'(stall_cnt[i]), 64'(m_stall[i]));
      chk($sformatf("flush_cnt[d%0d]", depth[i]), 64'(flush_cnt[i]), 64'(m_flush[i]));
`endif
    end
  endtask

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int unsigned n = mq[i].size();
      bit push = in_valid && (n != depth[i]);
      bit pop  = (n != 0) && out_ready;
      if ((n != 0) && !out_ready && (m_stall[i] < 65535)) m_stall[i]++;
      if (flush && (n != 0) && (m_flush[i] < 65535)) m_flush[i]++;
      if (flush) begin
        mq[i].delete();
      end else begin
        if (pop) void'(mq[i].pop_front());
        if (push) mq[i].push_back({instr_in, pc_in});
      end
    end
  endtask

  // Check current outputs, clock once, land on the following falling edge.
  task automatic step();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    depth[0] = 2;  nop[0] = 32'h0000_0000;
    depth[1] = 4;  nop[1] = 32'h0000_0013;
    model_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr_in = '0; pc_in = '0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      instr_in = 32'hA0 + 32'(k);
      pc_in    = 32'h100 + 32'(4 * k);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Fill with downstream stalled, then drain.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      instr_in = 32'hB0 + 32'(k);
      pc_in    = 32'h200 + 32'(4 * k);
      step();
    end
    step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // Random traffic exercising pointer wrap.
    for (int k = 0; k < 40; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr_in  = $urandom();
      pc_in     = $urandom();
      step();
    end

    // Asynchronous reset mid-cycle with entries held.
    out_ready = 1'b0; in_valid = 1'b1;
    instr_in = 32'hC0; pc_in = 32'h300; step();
    instr_in = 32'hC1; pc_in = 32'h304; step();
    in_valid = 1'b0;
    check_outputs();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Flush with push and pop in the same cycle (3 entries in DEPTH=4).
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr_in = 32'hD0 + 32'(k);
      pc_in    = 32'h400 + 32'(4 * k);
      step();
    end
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    instr_in = 32'hDF; pc_in = 32'h4FC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("flush_cnt_once_d4", 64'(flush_cnt[1]), 64'd1);
`endif

    // Random traffic with occasional flushes.
    for (int k = 0; k < 200; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      instr_in  = $urandom();
      pc_in     = $urandom();
      step();
    end
    flush = 1'b0;

`ifdef PIPE_STAGE_BUF_PERF_EN
    // Stall counter saturation.
    out_ready = 1'b0; in_valid = 1'b1;
    instr_in = 32'hE0; pc_in = 32'h500;
    repeat (70000) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    chk("stall_sat_d2", 64'(stall_cnt[0]), 64'hFFFF);
    chk("stall_sat_d4", 64'(stall_cnt[1]), 64'hFFFF);
    repeat (3) step();
    in_valid = 1'b0;
`endif

    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
